line_align_stream: RTL



---
 rtl/line_align_stream_if.sv | 32 +++
 rtl/line_align_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/line_align_stream_if.sv
// Pixel stream bus for the line aligner: tagged (x, y) pixel input and
// framed raster output, each with its own valid/ready handshake.
interface line_align_stream_if #(
  parameter int DW = 24,
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int OW = 16
);
  logic [DW-1:0] din;
  logic [XW-1:0] din_x;
  logic [YW-1:0] din_y;
  logic          din_valid;
  logic          din_ready;

  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_sof;
  logic          dout_eol;
  logic          dout_eof;
  logic [YW-1:0] rd_line;

  modport master (
    output din, din_x, din_y, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_sof, dout_eol, dout_eof, rd_line
  );

  modport slave (
    input  din, din_x, din_y, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_sof, dout_eol, dout_eof, rd_line
  );
endinterface

// File: rtl/line_align_stream.sv
// Reorders out-of-order (x, y) pixel writes into an NBUF-line buffer and
// streams each completed line in raster order with sof/eol/eof framing.
module line_align_stream #(
  parameter int H_DISP  = 1280,
  parameter int V_DISP  = 720,
  parameter int DW      = 24,
  parameter int NBUF    = 4,
  parameter int PACK565 = 1,
  parameter int XW      = $clog2(H_DISP),
  parameter int YW      = $clog2(V_DISP),
  parameter int OW      = (PACK565 != 0) ? 16 : DW
) (
  input logic               clk,
  input logic               rst_n,
  line_align_stream_if.slave bus
);

  localparam int SW    = $clog2(NBUF);
  localparam int CW    = $clog2(H_DISP + 1);
  localparam int DEPTH = NBUF * H_DISP;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_FREE, S_FILL, S_FULL} slot_state_e;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_e;

  slot_state_e   slot_st  [NBUF];
  logic [YW-1:0] slot_tag [NBUF];
  logic [CW-1:0] slot_cnt [NBUF];

  rd_state_e     rd_state;
  logic [YW-1:0] rd_line;
  logic [CW-1:0] rd_x;
  logic [XW-1:0] out_x;
  logic          rd_vld;
  logic          skid_vld;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] skid_data;
  logic [DW-1:0] mem [DEPTH];

  // ---------------- write side ----------------
  logic [SW-1:0] wr_slot;
  logic [YW:0]   y_dist;
  logic          in_window;
  logic          slot_ok;
  logic          din_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign wr_slot = bus.din_y[SW-1:0];

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    y_dist = '0;
    if (bus.din_y >= rd_line)
      y_dist = {1'b0, bus.din_y} - {1'b0, rd_line};
    else
      y_dist = {1'b0, bus.din_y} + (YW+1)'(V_DISP) - {1'b0, rd_line};
  end

  assign in_window = (y_dist < (YW+1)'(NBUF));
  assign slot_ok   = (slot_st[wr_slot] == S_FREE) ||
                     (slot_st[wr_slot] == S_FILL && slot_tag[wr_slot] == bus.din_y);
  assign din_ready = rst_n && in_window && slot_ok;
  assign wr_en     = bus.din_valid && din_ready;
  assign wr_addr   = AW'(wr_slot) * AW'(H_DISP) + AW'(bus.din_x);

  // ---------------- read side ----------------
  logic [SW-1:0] rd_slot;
  logic [YW-1:0] nxt_line;
  logic [SW-1:0] nxt_slot;
  logic          line_ready;
  logic          nxt_ready;
  logic          head_vld;
  logic [DW-1:0] head;
  logic          pop;
  logic          last_pop;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  assign rd_slot    = rd_line[SW-1:0];
  assign nxt_line   = (rd_line == YW'(V_DISP - 1)) ? '0 : rd_line + 1'b1;
  assign nxt_slot   = nxt_line[SW-1:0];
  assign line_ready = (slot_st[rd_slot] == S_FULL) && (slot_tag[rd_slot] == rd_line);
  assign nxt_ready  = (slot_st[nxt_slot] == S_FULL) && (slot_tag[nxt_slot] == nxt_line);

  // Skid entry is always older than the RAM output register.
  assign head_vld = skid_vld | rd_vld;
  assign head     = skid_vld ? skid_data : rd_data;
  assign pop      = head_vld && bus.dout_ready;
  assign last_pop = pop && (out_x == XW'(H_DISP - 1));

  // A new read may land only where the two-entry store has room after this cycle's pop.
  assign rd_en   = (rd_state == PRIME) ||
                   (rd_state == STREAM && rd_x < CW'(H_DISP) && (!rd_vld || !skid_vld || pop));
  assign rd_addr = AW'(rd_slot) * AW'(H_DISP) + AW'(rd_x);

  // NOTE: the pixel store carries no reset; its contents are only read once a line is FULL.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) begin
        slot_st[i]  <= S_FREE;
        slot_tag[i] <= '0;
        slot_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBUF; i++) begin
        if (last_pop && rd_slot == SW'(i)) begin
          slot_st[i]  <= S_FREE;
          slot_cnt[i] <= '0;
        end else if (wr_en && wr_slot == SW'(i)) begin
          slot_cnt[i] <= slot_cnt[i] + 1'b1;
          if (slot_st[i] == S_FREE) begin
            slot_st[i]  <= S_FILL;
            slot_tag[i] <= bus.din_y;
          end
        end else if (slot_st[i] == S_FILL && slot_cnt[i] == CW'(H_DISP)) begin
          slot_st[i] <= S_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state  <= IDLE;
      rd_line   <= '0;
      rd_x      <= '0;
      out_x     <= '0;
      rd_vld    <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else begin
      if (rd_en) begin
        rd_vld <= 1'b1;
        if (skid_vld && !pop) begin
          skid_vld <= 1'b1;
        end else if (rd_vld && (skid_vld || !pop)) begin
          skid_data <= rd_data;
          skid_vld  <= 1'b1;
        end else begin
          skid_vld <= 1'b0;
        end
        rd_x <= rd_x + 1'b1;
      end else if (pop) begin
        if (skid_vld) skid_vld <= 1'b0;
        else          rd_vld   <= 1'b0;
      end

      if (pop) out_x <= out_x + 1'b1;

      case (rd_state)
        IDLE:   if (line_ready) rd_state <= PRIME;
        PRIME:  rd_state <= STREAM;
        STREAM: if (last_pop) begin
          out_x    <= '0;
          rd_x     <= '0;
          rd_line  <= nxt_line;
          rd_state <= nxt_ready ? PRIME : IDLE;
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign bus.din_ready  = din_ready;
  assign bus.rd_line    = rd_line;
  assign bus.dout_valid = head_vld;
  assign bus.dout_eol   = head_vld && (out_x == XW'(H_DISP - 1));
  assign bus.dout_sof   = head_vld && (out_x == '0) && (rd_line == '0);
  assign bus.dout_eof   = bus.dout_eol && (rd_line == YW'(V_DISP - 1));

  generate
    if (PACK565 != 0) begin : g_pack
      logic unused_bits;
      assign unused_bits = ^{head[18:16], head[9:8], head[2:0]};
      assign bus.dout    = {head[23:19], head[15:10], head[7:3]};
    end else begin : g_raw
      assign bus.dout = head;
    end
  endgenerate

endmodule
